// File: rtl/config_pkg.sv
// config_pkg: shared config-stream constants, FSM state type and address-word field layout
package config_pkg;
  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;
  localparam int FRAME_SELECT_WIDTH = 5;
  localparam int DESYNC_FLAG = 20;
  localparam int COL_MSB = 31;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
endpackage

// File: rtl/frame_select_decoder.sv
// frame_select_decoder: range-checks a column/frame address and one-hot decodes it when enabled
module frame_select_decoder
  import config_pkg::*;
#(
  parameter int NUMBER_OF_COLS = 5,
  parameter int MAX_FRAMES_PER_COL = 20
) (
  input  logic [FRAME_SELECT_WIDTH-1:0]                col_i,
  input  logic [FRAME_SELECT_WIDTH-1:0]                frm_i,
  input  logic                                         en_i,
  output logic [MAX_FRAMES_PER_COL*NUMBER_OF_COLS-1:0] sel_o,
  output logic                                         valid_o
);
  assign valid_o = (int'(col_i) < NUMBER_OF_COLS) && (int'(frm_i) < MAX_FRAMES_PER_COL);
  for (genvar i = 0; i < MAX_FRAMES_PER_COL*NUMBER_OF_COLS; i++) begin : g_sel
    assign sel_o[i] = en_i && valid_o && (i == int'(col_i)*MAX_FRAMES_PER_COL + int'(frm_i));
  end
endmodule

// File: rtl/config_frame_loader.sv
// config_frame_loader: syncs on the config write stream, assembles row words into frames and strobes them out
module config_frame_loader
  import config_pkg::*;
#(
  parameter int NUMBER_OF_ROWS = 4,
  parameter int NUMBER_OF_COLS = 5,
  parameter int FRAME_BITS_PER_ROW = 32,
  parameter int MAX_FRAMES_PER_COL = 20
) (
  input  logic                                         clk_system_i,
  input  logic                                         reset_i,
  input  logic [FRAME_BITS_PER_ROW-1:0]                write_data_i,
  input  logic                                         write_strobe_i,
  output logic [NUMBER_OF_ROWS*FRAME_BITS_PER_ROW-1:0] frame_data_o,
  output logic [MAX_FRAMES_PER_COL*NUMBER_OF_COLS-1:0] frame_select_o,
  output logic                                         frame_strobe_o,
  output logic                                         active_o,
  output logic                                         error_o
);
  localparam int FW = NUMBER_OF_ROWS*FRAME_BITS_PER_ROW;
  localparam int CW = $clog2(NUMBER_OF_ROWS+1);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [FRAME_SELECT_WIDTH-1:0] col_q, frm_q;
  logic [FW-1:0] data_q;
  logic [MAX_FRAMES_PER_COL*NUMBER_OF_COLS-1:0] sel_q, sel_d;
  logic strobe_q, error_q, last, valid, sync;
  assign sync = write_data_i == SYNC_WORD;
  assign last = write_strobe_i && state_q == DATA && cnt_q == CW'(NUMBER_OF_ROWS-1);
  frame_select_decoder #(
    .NUMBER_OF_COLS(NUMBER_OF_COLS),
    .MAX_FRAMES_PER_COL(MAX_FRAMES_PER_COL)
  ) u_dec (
    .col_i(col_q),
    .frm_i(frm_q),
    .en_i(last),
    .sel_o(sel_d),
    .valid_o(valid)
  );
  always_ff @(posedge clk_system_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      col_q <= '0;
      frm_q <= '0;
      data_q <= '0;
      sel_q <= '0;
      strobe_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      strobe_q <= last && valid;
      sel_q <= sel_d;
      if (last && !valid) error_q <= 1'b1;
      if (write_strobe_i) begin
        case (state_q)
          IDLE: if (sync) begin
            state_q <= ADDR;
            error_q <= 1'b0;
          end
          ADDR: if (sync) error_q <= 1'b0;
            else if (write_data_i[DESYNC_FLAG]) state_q <= IDLE;
            else begin
              col_q <= write_data_i[COL_MSB -: FRAME_SELECT_WIDTH];
              frm_q <= write_data_i[FRAME_SELECT_WIDTH-1:0];
              cnt_q <= '0;
              state_q <= DATA;
            end
          DATA: begin
            data_q <= {data_q[FW-FRAME_BITS_PER_ROW-1:0], write_data_i};
            cnt_q <= cnt_q + 1'b1;
            if (last) state_q <= ADDR;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign frame_data_o = data_q;
  assign frame_select_o = sel_q;
  assign frame_strobe_o = strobe_q;
  assign active_o = state_q != IDLE;
  assign error_o = error_q;
endmodule

// File: tb/tb_config_frame_loader.sv
// tb_config_frame_loader: directed scenario checks of sync, framing, bad-address, desync and reset behaviour
module tb_config_frame_loader;
  logic clk = 1'b0, rst = 1'b0, ws = 1'b0;
  logic [31:0] wd = '0;
  logic [127:0] fd;
  logic [99:0] fs, exp_sel;
  logic fstb, act, err;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  config_frame_loader dut (
    .clk_system_i(clk),
    .reset_i(rst),
    .write_data_i(wd),
    .write_strobe_i(ws),
    .frame_data_o(fd),
    .frame_select_o(fs),
    .frame_strobe_o(fstb),
    .active_o(act),
    .error_o(err)
  );
  task automatic wr(input logic [31:0] w);
    @(negedge clk);
    wd = w;
    ws = 1'b1;
  endtask
  task automatic idle();
    @(negedge clk);
    ws = 1'b0;
    wd = '0;
  endtask
  task automatic frame(input logic [31:0] a, w0, w1, w2, w3);
    wr(a); wr(w0); wr(w1); wr(w2); wr(w3);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ws = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    tests++; if (fstb !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b expected 0", fstb); end
    tests++; if (fs !== '0) begin fails++; $display("FAIL reset_select: got %h expected 0", fs); end
    tests++; if (fd !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", fd); end
    tests++; if (act !== 1'b0) begin fails++; $display("FAIL reset_active: got %b expected 0", act); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", err); end
  endtask
  task automatic test_basic_frame();
    do_reset();
    wr(32'hFAB0_FAB1);
    frame(32'h1000_0003, 32'hA, 32'hB, 32'hC, 32'hD);
    idle();
    exp_sel = '0; exp_sel[43] = 1'b1;
    tests++; if (fstb !== 1'b1) begin fails++; $display("FAIL basic_strobe: got %b expected 1", fstb); end
    tests++; if (fs !== exp_sel) begin fails++; $display("FAIL basic_select: got %h expected %h", fs, exp_sel); end
    tests++; if (fd !== {32'hA, 32'hB, 32'hC, 32'hD}) begin fails++; $display("FAIL basic_data: got %h expected %h", fd, {32'hA, 32'hB, 32'hC, 32'hD}); end
    tests++; if (act !== 1'b1) begin fails++; $display("FAIL basic_active: got %b expected 1", act); end
    idle();
    tests++; if (fstb !== 1'b0 || fs !== '0) begin fails++; $display("FAIL basic_pulse_width: got strobe %b select %h expected 0 0", fstb, fs); end
  endtask
  task automatic test_pre_sync();
    do_reset();
    frame(32'h1000_0003, 32'h1, 32'h2, 32'h3, 32'h4);
    for (int i = 0; i < 3; i++) begin
      idle();
      tests++; if (fstb !== 1'b0 || act !== 1'b0) begin fails++; $display("FAIL presync_quiet: got strobe %b active %b expected 0 0", fstb, act); end
    end
    tests++; if (fd !== '0) begin fails++; $display("FAIL presync_data: got %h expected 0", fd); end
    wr(32'hFAB0_FAB1);
    idle();
    tests++; if (act !== 1'b1) begin fails++; $display("FAIL presync_active_after_sync: got %b expected 1", act); end
  endtask
  task automatic test_bad_addr();
    do_reset();
    wr(32'hFAB0_FAB1);
    frame(32'h3800_0000, 32'h11, 32'h22, 32'h33, 32'h44);
    idle();
    tests++; if (fstb !== 1'b0 || fs !== '0) begin fails++; $display("FAIL badcol_strobe: got strobe %b select %h expected 0 0", fstb, fs); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL badcol_error: got %b expected 1", err); end
    tests++; if (fd !== {32'h11, 32'h22, 32'h33, 32'h44}) begin fails++; $display("FAIL badcol_consumed: got %h expected %h", fd, {32'h11, 32'h22, 32'h33, 32'h44}); end
    frame(32'h0000_0014, 32'h5, 32'h6, 32'h7, 32'h8);
    idle();
    tests++; if (fstb !== 1'b0 || fs !== '0 || err !== 1'b1) begin fails++; $display("FAIL badfrm: got strobe %b select %h error %b expected 0 0 1", fstb, fs, err); end
    wr(32'hFAB0_FAB1);
    idle();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL resync_clears_error: got %b expected 0", err); end
    frame(32'h0000_0013, 32'h9, 32'hA, 32'hB, 32'hC);
    idle();
    exp_sel = '0; exp_sel[19] = 1'b1;
    tests++; if (fstb !== 1'b1 || fs !== exp_sel) begin fails++; $display("FAIL recover_frame: got strobe %b select %h expected 1 %h", fstb, fs, exp_sel); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL recover_error: got %b expected 0", err); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    wr(32'hFAB0_FAB1);
    frame(32'h0000_0000, 32'h100, 32'hFAB0_FAB1, 32'h102, 32'h103);
    wr(32'h2000_0013);
    exp_sel = '0; exp_sel[0] = 1'b1;
    tests++; if (fstb !== 1'b1 || fs !== exp_sel) begin fails++; $display("FAIL b2b_first_strobe: got strobe %b select %h expected 1 %h", fstb, fs, exp_sel); end
    tests++; if (fd !== {32'h100, 32'hFAB0_FAB1, 32'h102, 32'h103}) begin fails++; $display("FAIL b2b_first_data: got %h expected %h", fd, {32'h100, 32'hFAB0_FAB1, 32'h102, 32'h103}); end
    wr(32'h200);
    tests++; if (fstb !== 1'b0 || fd !== {32'h100, 32'hFAB0_FAB1, 32'h102, 32'h103}) begin fails++; $display("FAIL b2b_hold: got strobe %b data %h expected 0 frame1", fstb, fd); end
    wr(32'h201); wr(32'h202); wr(32'h203);
    idle();
    exp_sel = '0; exp_sel[99] = 1'b1;
    tests++; if (fstb !== 1'b1 || fs !== exp_sel) begin fails++; $display("FAIL b2b_second_strobe: got strobe %b select %h expected 1 %h", fstb, fs, exp_sel); end
    tests++; if (fd !== {32'h200, 32'h201, 32'h202, 32'h203}) begin fails++; $display("FAIL b2b_second_data: got %h expected %h", fd, {32'h200, 32'h201, 32'h202, 32'h203}); end
  endtask
  task automatic test_desync();
    do_reset();
    wr(32'hFAB0_FAB1);
    wr(32'h0010_0000);
    idle();
    tests++; if (act !== 1'b0) begin fails++; $display("FAIL desync_active: got %b expected 0", act); end
    frame(32'h1000_0003, 32'h1, 32'h2, 32'h3, 32'h4);
    idle();
    tests++; if (fstb !== 1'b0 || act !== 1'b0 || fd !== '0) begin fails++; $display("FAIL desync_ignored: got strobe %b active %b data %h expected 0 0 0", fstb, act, fd); end
    wr(32'hFAB0_FAB1);
    idle();
    tests++; if (act !== 1'b1) begin fails++; $display("FAIL desync_resync: got %b expected 1", act); end
  endtask
  task automatic test_mid_reset();
    do_reset();
    wr(32'hFAB0_FAB1);
    wr(32'h1000_0003);
    wr(32'hDEAD_0001);
    wr(32'hDEAD_0002);
    @(negedge clk);
    rst = 1'b1;
    ws = 1'b0;
    @(negedge clk);
    tests++; if (fd !== '0 || fs !== '0 || fstb !== 1'b0 || act !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL midreset_outputs: got data %h select %h strobe %b active %b error %b expected all 0", fd, fs, fstb, act, err); end
    rst = 1'b0;
    wr(32'hFAB0_FAB1);
    frame(32'h0800_0001, 32'h51, 32'h52, 32'h53, 32'h54);
    idle();
    exp_sel = '0; exp_sel[21] = 1'b1;
    tests++; if (fstb !== 1'b1 || fs !== exp_sel) begin fails++; $display("FAIL midreset_strobe: got strobe %b select %h expected 1 %h", fstb, fs, exp_sel); end
    tests++; if (fd !== {32'h51, 32'h52, 32'h53, 32'h54}) begin fails++; $display("FAIL midreset_data: got %h expected %h", fd, {32'h51, 32'h52, 32'h53, 32'h54}); end
    idle();
    tests++; if (fstb !== 1'b0) begin fails++; $display("FAIL midreset_single: got %b expected 0", fstb); end
  endtask
  initial begin
    test_reset();
    test_basic_frame();
    test_pre_sync();
    test_bad_addr();
    test_back_to_back();
    test_desync();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
